fifo_read_stream: RTL and testbench

- Read-side consumer of the async FIFO, in the read clock domain.
- Pops first-word-fall-through words (read_en / read_data / empty) and presents them as a registered valid/ready stream through a 2-entry skid buffer.
- Sustains one word per cycle with no combinational path from m_ready to fifo_read_en.
- Provides a synchronous flush and delivered/dropped word counters for debug.

---
 rtl/afifo_pkg.sv | 14 +
 rtl/fifo_read_stream.sv | 105 ++++++++++
 tb/tb_fifo_read_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO read-side stream logic.
//   stream_buf_state_t : occupancy state of the 2-entry output skid buffer
//   STREAM_BUF_DEPTH   : number of words the skid buffer can hold
package afifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no words buffered
        ONE   = 2'd1,   // head register valid
        FULL  = 2'd2    // head + skid valid
    } stream_buf_state_t;

    localparam int STREAM_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_read_stream.sv
// Read-side consumer of the async FIFO. Pops first-word-fall-through words
// and presents them as a registered valid/ready stream through a 2-entry
// skid buffer. fifo_read_en never depends on m_ready, so there is no
// combinational path from the downstream ready to the FIFO pop.
//
// Ports:
//   clk             read-domain clock
//   reset           synchronous active-high reset
//   fifo_read_en    pop strobe to the FIFO
//   fifo_read_data  FIFO head word (valid while !fifo_empty)
//   fifo_empty      FIFO empty flag
//   flush           synchronous discard of buffered words
//   m_valid/m_data/m_ready  output stream
//   delivered_count words accepted downstream (wraps)
//   dropped_count   words discarded by flush (wraps)
module fifo_read_stream
    import afifo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   fifo_read_en,
    input  logic [WIDTH-1:0]       fifo_read_data,
    input  logic                   fifo_empty,
    input  logic                   flush,
    output logic                   m_valid,
    output logic [WIDTH-1:0]       m_data,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] delivered_count,
    output logic [COUNT_WIDTH-1:0] dropped_count
);

    localparam int OCC_W = $clog2(STREAM_BUF_DEPTH + 1);

    stream_buf_state_t  state;
    logic [WIDTH-1:0]   head;
    logic [WIDTH-1:0]   skid;
    logic [OCC_W-1:0]   occupancy;
    logic               pop;
    logic               hs;

    // Only pop from a legal non-full state; an illegal encoding must not
    // swallow a FIFO word while it recovers to EMPTY.
    assign pop          = !fifo_empty && (state == EMPTY || state == ONE)
                          && !flush && !reset;
    assign fifo_read_en = pop;

    assign m_valid = (state == ONE) || (state == FULL);
    assign m_data  = head;
    assign hs      = m_valid && m_ready;

    always_comb begin
        occupancy = '0;
        case (state)
            ONE:     occupancy = OCC_W'(1);
            FULL:    occupancy = OCC_W'(2);
            default: occupancy = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= EMPTY;
            head            <= '0;
            skid            <= '0;
            delivered_count <= '0;
            dropped_count   <= '0;
        end else if (flush) begin
            // Head is counted as dropped even if it handshakes this cycle.
            state         <= EMPTY;
            dropped_count <= dropped_count + COUNT_WIDTH'(occupancy);
        end else begin
            if (hs)
                delivered_count <= delivered_count + COUNT_WIDTH'(1);
            case (state)
                EMPTY: begin
                    if (pop) begin
                        head  <= fifo_read_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (pop && hs) begin
                        head <= fifo_read_data;   // full-throughput case
                    end else if (pop) begin
                        skid  <= fifo_read_data;
                        state <= FULL;
                    end else if (hs) begin
                        state <= EMPTY;           // head left stale
                    end
                end
                FULL: begin
                    if (hs) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_stream.sv
module tb_fifo_read_stream;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_read_en;
    logic [W-1:0]  fifo_read_data;
    logic          fifo_empty;
    logic          flush;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic [CW-1:0] delivered_count;
    logic [CW-1:0] dropped_count;

    fifo_read_stream #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .fifo_empty     (fifo_empty),
        .flush          (flush),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .delivered_count(delivered_count),
        .dropped_count  (dropped_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // source FIFO contents, reference buffer model, and DUT-accepted words
    logic [W-1:0] src[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    int mdel  = 0;
    int mdrop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic fl, input logic rst, input logic gate);
        m_ready        = rdy;
        flush          = fl;
        reset          = rst;
        fifo_empty     = gate || (src.size() == 0);
        fifo_read_data = (src.size() > 0) ? src[0] : '0;
    endtask

    // One clock: drive, check against the model, advance FIFO + model.
    task automatic cycle(input logic rdy, input logic fl, input logic rst, input logic gate);
        logic         exp_ren;
        logic         ren_s;
        logic [W-1:0] dval;
        int           occ;
        drive(rdy, fl, rst, gate);
        #1;
        exp_ren = !fifo_empty && (mq.size() < 2) && !fl && !rst;
        chk("read_en", fifo_read_en, exp_ren);
        chk("valid", m_valid, mq.size() > 0);
        if (mq.size() > 0) chk("data", m_data, mq[0]);
        chk("delivered", delivered_count, 32'(mdel % (1 << CW)));
        chk("dropped", dropped_count, 32'(mdrop % (1 << CW)));
        if (m_valid && m_ready && !fl && !rst) got.push_back(m_data);
        ren_s = fifo_read_en;
        dval  = fifo_read_data;
        @(posedge clk);
        if (ren_s && src.size() > 0) void'(src.pop_front());
        if (rst) begin
            mq.delete(); mdel = 0; mdrop = 0;
        end else if (fl) begin
            occ = mq.size();
            mdrop += occ;
            mq.delete();
        end else begin
            if (mq.size() > 0 && rdy) begin
                void'(mq.pop_front());
                mdel++;
            end
            if (exp_ren) mq.push_back(dval);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        src.delete();
        got.delete();
    endtask

    typedef struct {
        logic         rdy;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_ren;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic         pv, pr;
        logic [W-1:0] pd;
        int           cyc;

        tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b1};
        tbl[1] = '{1'b0, 1'b1, 32'hA1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 32'hA1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'hA1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'hA1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'hA2, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 32'hA3, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b0};

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        do_reset();
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_deliv", delivered_count, 32'h0);
        chk("rst_drop", dropped_count, 32'h0);

        // throughput
        src = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("tp_w0", got[0], 32'h11);
            chk("tp_w1", got[1], 32'h22);
            chk("tp_w2", got[2], 32'h33);
        end
        chk("tp_deliv", delivered_count, 32'd3);

        // backpressure (table driven)
        do_reset();
        src = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rdy, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("bp_valid[%0d]", i), m_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("bp_data[%0d]", i), m_data, tbl[i].exp_data);
            chk($sformatf("bp_ren[%0d]", i), fifo_read_en, tbl[i].exp_ren);
            cycle(tbl[i].rdy, 1'b0, 1'b0, 1'b0);
        end
        chk("bp_deliv", delivered_count, 32'd3);

        // flush from FULL with m_ready high
        do_reset();
        src = '{32'hB1, 32'hB2, 32'hB3};
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fl_ren", fifo_read_en, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("fl_valid", m_valid, 1'b0);
        chk("fl_drop", dropped_count, 32'd2);
        chk("fl_deliv", delivered_count, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fl_next", m_data, 32'hB3);
        chk("fl_next_v", m_valid, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // reset mid-operation
        src = '{32'hC1, 32'hC2, 32'hC3};
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("mr_ren", fifo_read_en, 1'b0);
        do_reset();
        chk("mr_valid", m_valid, 1'b0);
        chk("mr_data", m_data, 32'h0);
        chk("mr_deliv", delivered_count, 32'h0);
        chk("mr_drop", dropped_count, 32'h0);

        // counter wrap: 17 words through a 4-bit counter
        for (int i = 0; i < 17; i++) src.push_back(32'h100 + i);
        for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_deliv", delivered_count, 32'd1);
        chk("wrap_count", got.size(), 17);

        // sparse source, random ready
        do_reset();
        for (int i = 1; i <= 8; i++) src.push_back(32'(i));
        pv = 1'b0; pr = 1'b0; pd = '0;
        cyc = 0;
        while (got.size() < 8 && cyc < 300) begin
            if (pv && !pr) begin
                drive(1'b0, 1'b0, 1'b0, 1'(cyc % 2));
                #1;
                chk("sp_stable_v", m_valid, 1'b1);
                chk("sp_stable_d", m_data, pd);
            end
            pr = 1'($urandom_range(0, 1));
            cycle(pr, 1'b0, 1'b0, 1'(cyc % 2));
            pv = m_valid; pd = m_data;
            cyc++;
        end
        chk("sp_timeout", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("sp_word[%0d]", i), got[i], 32'(i + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
